// File: rtl/kitchen_timer_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kitchen_timer_core_pkg
// Description : Shared state encoding, BCD limits and time arithmetic helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package kitchen_timer_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_DIGIT_MAX = 4'd9;
    localparam logic [3:0] c_TENS_MAX  = 4'd5;

    typedef struct packed {
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
    } bcd_time_t;

    function automatic logic is_zero(input bcd_time_t t);
        return (t == '0);
    endfunction

    // Seconds wrap 59 -> 00 without touching the minutes.
    function automatic bcd_time_t inc_sec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec0 == c_DIGIT_MAX) begin
            r.sec0 = 4'd0;
            r.sec1 = (t.sec1 == c_TENS_MAX) ? 4'd0 : t.sec1 + 4'd1;
        end else begin
            r.sec0 = t.sec0 + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t inc_min(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.min0 == c_DIGIT_MAX) begin
            r.min0 = 4'd0;
            r.min1 = (t.min1 == c_DIGIT_MAX) ? 4'd0 : t.min1 + 4'd1;
        end else begin
            r.min0 = t.min0 + 4'd1;
        end
        return r;
    endfunction

    // Only called with a nonzero time, so the min1 borrow never underflows.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec0 != 4'd0) begin
            r.sec0 = t.sec0 - 4'd1;
        end else begin
            r.sec0 = c_DIGIT_MAX;
            if (t.sec1 != 4'd0) begin
                r.sec1 = t.sec1 - 4'd1;
            end else begin
                r.sec1 = c_TENS_MAX;
                if (t.min0 != 4'd0) begin
                    r.min0 = t.min0 - 4'd1;
                end else begin
                    r.min0 = c_DIGIT_MAX;
                    r.min1 = t.min1 - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kitchen_timer_core_if.sv
`default_nettype none
// ============================================================================
// Module      : kitchen_timer_core_if
// Description : Button pulses in, BCD digits and status flags out.
// Revision    : 1.0 - initial release
// ============================================================================
interface kitchen_timer_core_if;
    logic       start_stop;
    logic       clear;
    logic       inc_min;
    logic       inc_sec;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic       running;
    logic       alarm;

    modport master (
        output start_stop, clear, inc_min, inc_sec,
        input  min1, min0, sec1, sec0, running, alarm
    );

    modport slave (
        input  start_stop, clear, inc_min, inc_sec,
        output min1, min0, sec1, sec0, running, alarm
    );
endinterface
`default_nettype wire

// File: rtl/kitchen_timer_core_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Divides clk down to one tick per CLK_HZ enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int CLK_HZ = 100000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);
    localparam int         c_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(CLK_HZ - 1);

    logic [c_W-1:0] r_cnt;

    assign tick = en && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/kitchen_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : kitchen_timer_core
// Description : MM:SS countdown timer with set/run/pause/alarm control.
// Revision    : 1.0 - initial release
// ============================================================================
module kitchen_timer_core
    import kitchen_timer_core_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    kitchen_timer_core_if.slave bus
);
    state_t    r_state;
    state_t    w_state_nxt;
    bcd_time_t r_time;
    bcd_time_t w_time_nxt;
    logic      w_tick;
    logic      w_start;
    logic      w_pre_en;
    logic      w_pre_clr;

    assign w_start   = bus.start_stop && !is_zero(r_time) &&
                       (r_state == ST_IDLE || r_state == ST_PAUSE);
    // A start_stop in RUN freezes the prescaler even on its terminal count.
    assign w_pre_en  = (r_state == ST_RUN) && !bus.start_stop && !bus.clear;
    assign w_pre_clr = bus.clear || w_start;

    timer_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_pre_en),
        .clr  (w_pre_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_time  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_time  <= w_time_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        if (bus.clear) begin
            w_state_nxt = ST_IDLE;
            w_time_nxt  = '0;
        end else if (bus.start_stop) begin
            case (r_state)
                ST_IDLE, ST_PAUSE: if (w_start) w_state_nxt = ST_RUN;
                ST_RUN:            w_state_nxt = ST_PAUSE;
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_time_nxt  = '0;
                end
                default:           w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state == ST_RUN && w_tick) begin
            w_time_nxt = dec_time(r_time);
            if (is_zero(w_time_nxt)) w_state_nxt = ST_DONE;
        end else if (r_state == ST_IDLE || r_state == ST_PAUSE) begin
            if (bus.inc_sec) w_time_nxt = inc_sec(w_time_nxt);
            if (bus.inc_min) w_time_nxt = inc_min(w_time_nxt);
        end
    end

    assign bus.min1    = r_time.min1;
    assign bus.min0    = r_time.min0;
    assign bus.sec1    = r_time.sec1;
    assign bus.sec0    = r_time.sec0;
    assign bus.running = (r_state == ST_RUN);
    assign bus.alarm   = (r_state == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_kitchen_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_kitchen_timer_core
// Description : Scoreboard bench with a seconds-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kitchen_timer_core;
    localparam int c_CLK_HZ = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kitchen_timer_core_if bus();

    kitchen_timer_core #(
        .CLK_HZ (c_CLK_HZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [17:0] outv;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: 0 idle, 1 run, 2 pause, 3 done; time kept as total seconds.
    int m_state = 0;
    int m_secs  = 0;
    int m_pre   = 0;

    always @(posedge clk) cyc++;

    function automatic logic [17:0] model_out();
        int m;
        int s;
        m = m_secs / 60;
        s = m_secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                (m_state == 1), (m_state == 3)};
    endfunction

    task automatic model_step(input logic r, ss, cl, im, is);
        int m;
        int s;
        if (r || cl) begin
            m_state = 0; m_secs = 0; m_pre = 0;
        end else if (ss) begin
            if (m_state == 0 || m_state == 2) begin
                if (m_secs != 0) begin m_state = 1; m_pre = 0; end
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_state = 0; m_secs = 0;
            end
        end else if (m_state == 1) begin
            if (m_pre == c_CLK_HZ - 1) begin
                m_pre  = 0;
                m_secs = m_secs - 1;
                if (m_secs == 0) m_state = 3;
            end else begin
                m_pre++;
            end
        end else if (m_state == 0 || m_state == 2) begin
            m = m_secs / 60;
            s = m_secs % 60;
            if (is) s = (s + 1) % 60;
            if (im) m = (m + 1) % 100;
            m_secs = m * 60 + s;
        end
    endtask

    task automatic step(input logic r, ss, cl, im, is);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.start_stop = ss;
        bus.clear      = cl;
        bus.inc_min    = im;
        bus.inc_sec    = is;
        model_step(r, ss, cl, im, is);
        e.cyc  = cyc + 1;
        e.outv = model_out();
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge with a pending expectation is checked.
    initial begin
        exp_t        e;
        logic [17:0] act;
        forever begin
            @(negedge clk);
            act = {bus.min1, bus.min0, bus.sec1, bus.sec0, bus.running, bus.alarm};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missed_check cyc=%0d actual=none required=%h", e.cyc, e.outv);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_tests++;
                if (act !== e.outv) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d actual=%h%h:%h%h run=%b alarm=%b required=%h%h:%h%h run=%b alarm=%b",
                             cyc, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                             e.outv[17:14], e.outv[13:10], e.outv[9:6], e.outv[5:2],
                             e.outv[1], e.outv[0]);
                end
            end
        end
    end

    initial begin
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.inc_min    = 1'b0;
        bus.inc_sec    = 1'b0;

        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 61; i++) step(0, 0, 0, 0, 1);
        idle(2);

        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(12);

        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle(22);
        step(0, 1, 0, 0, 0);
        idle(2);

        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle(9);
        step(0, 1, 0, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0);
        idle(12);

        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle(3);
        step(0, 1, 1, 0, 0);
        idle(2);

        for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle(4);
        step(1, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0);
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 999) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 399) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0);

        idle(3);
        repeat (3) @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain actual=%0d pending required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/kitchen_timer_core.md
KITCHEN_TIMER_CORE -- requirements
Module: kitchen_timer_core

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning input clock cycles per one-second countdown tick.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start_stop, input, 1, single-cycle debounced pulse: start/pause/resume/acknowledge.
REQ-005 The block SHALL have port clear, input, 1, single-cycle pulse: abort and zero the timer.
REQ-006 The block SHALL have port inc_min, input, 1, single-cycle pulse: add one minute while setting.
REQ-007 The block SHALL have port inc_sec, input, 1, single-cycle pulse: add one second while setting.
REQ-008 The block SHALL have ports min1, min0, sec1, sec0, output, 4 each, registered BCD digits (minute tens, minute units, second tens, second units) for the digit-to-segment decoder.
REQ-009 The block SHALL have port running, output, 1, high only in RUN.
REQ-010 The block SHALL have port alarm, output, 1, high only in DONE.

Function
REQ-011 The block SHALL implement states IDLE (setting), RUN, PAUSE, DONE; running/alarm are decoded from registered state.
REQ-012 Digits SHALL always hold legal BCD: min1 0-9, min0 0-9, sec1 0-5, sec0 0-9; range 00:00-99:59.
REQ-013 In IDLE or PAUSE, inc_sec SHALL increment seconds 00->59 then wrap to 00 with no carry into minutes.
REQ-014 In IDLE or PAUSE, inc_min SHALL increment minutes 00->99 then wrap to 00; seconds unchanged.
REQ-015 inc_min and inc_sec SHALL be ignored in RUN and DONE; both asserted together in IDLE/PAUSE SHALL apply both.
REQ-016 start_stop in IDLE or PAUSE SHALL enter RUN next cycle if time is nonzero; at 00:00 it SHALL be ignored.
REQ-017 Entering RUN SHALL clear the prescaler; first decrement occurs exactly CLK_HZ cycles after the start_stop cycle.
REQ-018 In RUN the prescaler SHALL count 0..CLK_HZ-1; on terminal count it SHALL wrap to 0 and decrement time by one second.
REQ-019 Decrement SHALL borrow through the chain: sec0 0->9 borrows sec1, sec1 0->5 borrows min0, min0 0->9 borrows min1.
REQ-020 When a decrement yields 00:00, state SHALL become DONE in that same edge; alarm high the following cycle, running low.
REQ-021 start_stop in RUN SHALL enter PAUSE; time and prescaler frozen; a coincident terminal count SHALL NOT decrement.
REQ-022 start_stop in DONE SHALL enter IDLE with 00:00, alarm low.
REQ-023 clear in any state SHALL force IDLE, all digits 0, prescaler 0 on the next edge.
REQ-024 Priority SHALL be clear > start_stop > tick decrement > inc_min/inc_sec; inc pulses coincident with start_stop are dropped.
REQ-025 All pulse inputs SHALL take effect on the clock edge where sampled high; outputs update one cycle later, no combinational input-to-output path.

Reset
REQ-026 rst SHALL set state IDLE, min1=min0=sec1=sec0=0, prescaler 0, running=0, alarm=0, overriding all inputs.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort without a final decrement or alarm pulse.

Structure
REQ-028 State encoding and BCD limit constants (9, 5) SHALL live in the shared timer package.
REQ-029 The prescaler SHALL be sub-module timer_prescaler (inputs clk, rst, en, clr; output tick; parameter CLK_HZ).

Verification (CLK_HZ=10)
REQ-030 Reset then 61 inc_sec pulses -> 00:01, running=0, alarm=0.
REQ-031 Set 01:00, start_stop -> running=1; 10 cycles later 00:59 (full borrow).
REQ-032 Set 00:02, start_stop -> 20 cycles later 00:00, alarm=1; start_stop -> IDLE, alarm=0.
REQ-033 Run 00:05, start_stop on terminal-count cycle -> PAUSE at 00:05; resume -> 00:04 exactly 10 cycles later.
REQ-034 start_stop at 00:00 in IDLE -> no state change; clear with start_stop in RUN -> IDLE, 00:00.
REQ-035 inc_min 100 pulses from 00:00 -> 00:00; rst mid-RUN -> all outputs 0 next cycle.
